core_seq_ctrl: RTL and testbench

On-chip instruction sequencer for the systolic `core`. It replaces the bench-driven control stream with a registered 34-bit `inst` word. After `start`, it runs the full conv tile schedule:
- per kernel position kij: weight fetch to ififo, weight load, activation fetch to L0, execute, ofifo drain to psum memory;
- then the psum accumulation pass for every output pixel.

It sits between the host/test harness and `core.inst`, and observes `ofifo_valid`. Weights and activations must already be resident in xmem.

---
 rtl/core_ctrl_pkg.sv | 40 ++++
 rtl/ctrl_acc_addr.sv | 32 +++
 rtl/core_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: FSM states,
// instruction-word bit positions and the idle instruction word.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_FETCH,
    W_LOAD,
    GAP,
    A_FETCH,
    EXEC,
    DRAIN,
    ACC_CLR,
    ACC_RUN,
    ACC_OUT,
    DONE
  } state_e;

  localparam int INST_W = 34;
  localparam int A_W    = 11;

  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM   = 20;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  // Both memories disabled and write-protected, no datapath strobes.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

endpackage

// File: rtl/ctrl_acc_addr.sv
// Psum-memory address of kernel tap j for output pixel onij during the
// accumulation pass: psum block j, shifted by the kernel row/column offsets.
module ctrl_acc_addr
  import core_ctrl_pkg::*;
#(
  parameter int in_w  = 6,
  parameter int out_w = 4,
  parameter int k_w   = 3
) (
  input  logic [7:0]     onij,
  input  logic [7:0]     j,
  output logic [A_W-1:0] a_pmem
);

  localparam logic [A_W-1:0] IN_W    = A_W'(in_w);
  localparam logic [A_W-1:0] OUT_W   = A_W'(out_w);
  localparam logic [A_W-1:0] K_W     = A_W'(k_w);
  localparam logic [A_W-1:0] LEN_NIJ = A_W'(in_w * in_w);

  logic [A_W-1:0] onij_w, j_w, oy, ox, ky, kx;

  always_comb begin
    onij_w = {3'd0, onij};
    j_w    = {3'd0, j};
    oy     = onij_w / OUT_W;
    ox     = onij_w % OUT_W;
    ky     = j_w / K_W;
    kx     = j_w % K_W;
    a_pmem = LEN_NIJ * j_w + (oy + ky) * IN_W + ox + kx;
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// On-chip sequencer producing the registered 34-bit core instruction stream
// for a full conv tile: per-kij weight/activation/execute/drain, then psum accumulation.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int             bw     = 4,
  parameter int             row    = 8,
  parameter int             col    = 8,
  parameter int             in_w   = 6,
  parameter int             k_w    = 3,
  parameter int             out_w  = 4,
  parameter logic [A_W-1:0] w_base = 11'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              sfp_clr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  localparam int LEN_NIJ  = in_w * in_w;
  localparam int LEN_KIJ  = k_w * k_w;
  localparam int LEN_ONIJ = out_w * out_w;

  localparam logic [11:0] W_FETCH_LAST = 12'(2 * col);
  localparam logic [11:0] W_LOAD_LAST  = 12'(row + 3 * col - 1);
  localparam logic [11:0] GAP_LAST     = 12'd10;
  localparam logic [11:0] A_FETCH_LAST = 12'(2 * LEN_NIJ);
  localparam logic [11:0] EXEC_LAST    = 12'(2 * LEN_NIJ + row + col - 1);
  localparam logic [11:0] NIJ_T        = 12'(LEN_NIJ);
  localparam logic [11:0] KIJ_T        = 12'(LEN_KIJ);
  localparam logic [7:0]  KIJ_LAST     = 8'(LEN_KIJ - 1);
  localparam logic [7:0]  ONIJ_LAST    = 8'(LEN_ONIJ - 1);
  localparam logic [A_W-1:0] W_STRIDE  = A_W'(2 * col);
  localparam logic [A_W-1:0] NIJ_A     = A_W'(LEN_NIJ);

  // bw only documents the datapath width of the core being driven.
  if (bw <= 0) begin : g_bw_unused
  end

  state_e         state_q, nstate;
  logic [11:0]    t_q, nt;
  logic [7:0]     kij_q, nkij, onij_q, nonij;
  logic [A_W-1:0] acc_addr;
  logic [INST_W-1:0] ninst;
  logic           nclr, nov, nbusy, ndone;

  ctrl_acc_addr #(.in_w(in_w), .out_w(out_w), .k_w(k_w)) u_acc_addr (
    .onij   (nonij),
    .j      (nt[7:0]),
    .a_pmem (acc_addr)
  );

  // In DRAIN, t counts completed transfers; the registered ofifo_rd bit
  // says whether the current cycle is one.
  always_comb begin
    nstate = state_q;
    nt     = t_q + 12'd1;
    nkij   = kij_q;
    nonij  = onij_q;
    case (state_q)
      IDLE: begin
        nt = '0;
        if (start) nstate = W_FETCH;
      end
      W_FETCH: if (t_q == W_FETCH_LAST) begin nstate = W_LOAD;  nt = '0; end
      W_LOAD:  if (t_q == W_LOAD_LAST)  begin nstate = GAP;     nt = '0; end
      GAP:     if (t_q == GAP_LAST)     begin nstate = A_FETCH; nt = '0; end
      A_FETCH: if (t_q == A_FETCH_LAST) begin nstate = EXEC;    nt = '0; end
      EXEC:    if (t_q == EXEC_LAST)    begin nstate = DRAIN;   nt = '0; end
      DRAIN: begin
        nt = t_q + {11'd0, inst[INST_OFIFO_RD]};
        if (nt == NIJ_T) begin
          nt = '0;
          if (kij_q == KIJ_LAST) nstate = ACC_CLR;
          else begin
            nstate = W_FETCH;
            nkij   = kij_q + 8'd1;
          end
        end
      end
      ACC_CLR: begin nstate = ACC_RUN; nt = '0; end
      ACC_RUN: if (t_q == KIJ_T) begin nstate = ACC_OUT; nt = '0; end
      ACC_OUT: begin
        nt = '0;
        if (onij_q == ONIJ_LAST) nstate = DONE;
        else begin
          nstate = ACC_CLR;
          nonij  = onij_q + 8'd1;
        end
      end
      DONE: begin
        nstate = IDLE;
        nt     = '0;
        nkij   = '0;
        nonij  = '0;
      end
      default: begin
        nstate = IDLE;
        nt     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next-cycle state so they register in step with it.
  always_comb begin
    ninst = INST_IDLE;
    nclr  = 1'b0;
    nov   = 1'b0;
    ndone = 1'b0;
    nbusy = (nstate != IDLE) && (nstate != DONE);
    case (nstate)
      W_FETCH: begin
        if (nt < W_FETCH_LAST) begin
          ninst[INST_CEN_XMEM] = 1'b0;
          ninst[INST_A_XMEM +: A_W] = w_base + {3'd0, nkij} * W_STRIDE + nt[A_W-1:0];
        end
        ninst[INST_IFIFO_WR] = (nt != 12'd0);
      end
      W_LOAD: begin
        ninst[INST_IFIFO_RD] = 1'b1;
        ninst[INST_LOAD]     = 1'b1;
      end
      A_FETCH: begin
        if (nt < A_FETCH_LAST) begin
          ninst[INST_CEN_XMEM] = 1'b0;
          ninst[INST_A_XMEM +: A_W] = nt[A_W-1:0];
        end
        ninst[INST_L0_WR] = (nt != 12'd0);
      end
      EXEC: begin
        ninst[INST_L0_RD]   = 1'b1;
        ninst[INST_EXECUTE] = 1'b1;
      end
      DRAIN: begin
        if (ofifo_valid) begin
          ninst[INST_OFIFO_RD] = 1'b1;
          ninst[INST_CEN_PMEM] = 1'b0;
          ninst[INST_WEN_PMEM] = 1'b0;
          ninst[INST_A_PMEM +: A_W] = NIJ_A * {3'd0, nkij} + nt[A_W-1:0];
        end
      end
      ACC_CLR: nclr = 1'b1;
      ACC_RUN: begin
        if (nt < KIJ_T) begin
          ninst[INST_CEN_PMEM] = 1'b0;
          ninst[INST_A_PMEM +: A_W] = acc_addr;
        end
        ninst[INST_ACC] = (nt != 12'd0);
      end
      ACC_OUT: nov   = 1'b1;
      DONE:    ndone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      t_q       <= '0;
      kij_q     <= '0;
      onij_q    <= '0;
      inst      <= INST_IDLE;
      sfp_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= nstate;
      t_q       <= nt;
      kij_q     <= nkij;
      onij_q    <= nonij;
      inst      <= ninst;
      sfp_clr   <= nclr;
      out_valid <= nov;
      busy      <= nbusy;
      done      <= ndone;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a cycle-by-cycle schedule model built from nested
// phase loops, driven with directed and random ofifo_valid / start patterns.
module tb_core_seq_ctrl;
  import core_ctrl_pkg::*;

  localparam int ROW = 8, COL = 8, IN_W = 6, K_W = 3, OUT_W = 4;
  localparam int LEN_NIJ = IN_W * IN_W, LEN_KIJ = K_W * K_W, LEN_ONIJ = OUT_W * OUT_W;
  localparam int W_BASE = 'h400;
  localparam logic [6:0] C_OFIFO_RD = 7'b1000000, C_IFIFO_WR = 7'b0100000,
                         C_IFIFO_RD = 7'b0010000, C_L0_RD = 7'b0001000,
                         C_L0_WR = 7'b0000100, C_EXEC = 7'b0000010, C_LOAD = 7'b0000001;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        sfp_clr, out_valid, busy, done;
  state_e      dbg_state;

  core_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .sfp_clr     (sfp_clr),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cycles = 0, vmode = 0, stall_cnt = 0, done_seen = 0, ov_seen = 0, done_idx = -1;
  bit noise = 0;
  logic [37:0] exp_q[$];

  function automatic logic [33:0] mk(input logic acc, input logic cen_p, input logic wen_p,
                                     input int a_p, input logic cen_x, input int a_x,
                                     input logic [6:0] ctl);
    logic [10:0] ap, ax;
    ap = 11'(a_p);
    ax = 11'(a_x);
    return {acc, cen_p, wen_p, ap, cen_x, 1'b1, ax, ctl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Compare one cycle, then choose the inputs sampled at the next rising edge.
  task automatic expect_cycle(input string tag, input logic [33:0] e_inst, input logic e_clr,
                              input logic e_ov, input logic e_busy, input logic e_done);
    logic [37:0] e;
    @(negedge clk);
    exp_q.push_back({e_inst, e_clr, e_ov, e_busy, e_done});
    e = exp_q.pop_front();
    chk(tag, {26'd0, inst, sfp_clr, out_valid, busy, done}, {26'd0, e});
    if (done === 1'b1) begin done_seen++; done_idx = cycles; end
    if (out_valid === 1'b1) ov_seen++;
    cycles++;
    start = noise ? ($urandom_range(0, 15) == 0) : 1'b0;
    if (stall_cnt > 0) begin
      ofifo_valid = 1'b0;
      stall_cnt--;
    end else if (vmode == 2) ofifo_valid = ($urandom_range(0, 3) != 0);
    else ofifo_valid = 1'b1;
  endtask

  // Full tile schedule. mode 0: ofifo_valid always 1, 1: one 5-cycle stall
  // at kij=3 transfer 10, 2: random ofifo_valid.
  task automatic run_schedule(input int mode, input bit with_noise);
    int first_idx, n, guard, oy, ox, a;
    vmode = mode;
    noise = with_noise;
    ov_seen = 0;
    done_idx = -1;
    start = 1'b1;
    ofifo_valid = 1'b1;
    first_idx = cycles;
    for (int kij = 0; kij < LEN_KIJ; kij++) begin
      for (int t = 0; t <= 2 * COL; t++) begin
        expect_cycle("w_fetch", mk(0, 1, 1, 0, (t < 2 * COL) ? 1'b0 : 1'b1,
                     (t < 2 * COL) ? W_BASE + kij * 2 * COL + t : 0,
                     (t >= 1) ? C_IFIFO_WR : 7'd0), 0, 0, 1, 0);
        if (kij == 0 && t == 0) begin
          chk("first_a_xmem", {53'd0, inst[17:7]}, 64'h400);
          chk("first_ififo_wr", {63'd0, inst[5]}, 64'd0);
        end
        if (kij == 0 && t == 1) begin
          chk("second_a_xmem", {53'd0, inst[17:7]}, 64'h401);
          chk("second_ififo_wr", {63'd0, inst[5]}, 64'd1);
        end
      end
      for (int t = 0; t < ROW + 3 * COL; t++)
        expect_cycle("w_load", mk(0, 1, 1, 0, 1, 0, C_IFIFO_RD | C_LOAD), 0, 0, 1, 0);
      for (int t = 0; t < 11; t++)
        expect_cycle("gap", IDLE_W, 0, 0, 1, 0);
      for (int t = 0; t <= 2 * LEN_NIJ; t++)
        expect_cycle("a_fetch", mk(0, 1, 1, 0, (t < 2 * LEN_NIJ) ? 1'b0 : 1'b1,
                     (t < 2 * LEN_NIJ) ? t : 0, (t >= 1) ? C_L0_WR : 7'd0), 0, 0, 1, 0);
      for (int t = 0; t < 2 * LEN_NIJ + ROW + COL; t++)
        expect_cycle("exec", mk(0, 1, 1, 0, 1, 0, C_L0_RD | C_EXEC), 0, 0, 1, 0);
      n = 0;
      guard = 0;
      while (n < LEN_NIJ && guard < 1000) begin
        guard++;
        if (ofifo_valid) begin
          if (mode == 1 && kij == 3 && n == 9) stall_cnt = 5;
          expect_cycle("drain_xfer", mk(0, 0, 0, LEN_NIJ * kij + n, 1, 0, C_OFIFO_RD), 0, 0, 1, 0);
          n++;
        end else expect_cycle("drain_stall", IDLE_W, 0, 0, 1, 0);
      end
      if (n < LEN_NIJ) chk("drain_budget", 64'(n), 64'(LEN_NIJ));
    end
    for (int onij = 0; onij < LEN_ONIJ; onij++) begin
      oy = onij / OUT_W;
      ox = onij % OUT_W;
      expect_cycle("acc_clr", IDLE_W, 1, 0, 1, 0);
      for (int j = 0; j <= LEN_KIJ; j++) begin
        a = LEN_NIJ * j + (oy + j / K_W) * IN_W + (ox + j % K_W);
        expect_cycle("acc_run", mk((j >= 1) ? 1'b1 : 1'b0, (j < LEN_KIJ) ? 1'b0 : 1'b1, 1,
                     (j < LEN_KIJ) ? a : 0, 1, 0, 7'd0), 0, 0, 1, 0);
      end
      expect_cycle("acc_out", IDLE_W, 0, 1, 1, 0);
    end
    noise = 0;
    expect_cycle("done", IDLE_W, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) expect_cycle("post_idle", IDLE_W, 0, 0, 0, 0);
    chk("out_valid_pulses", 64'(ov_seen), 64'(LEN_ONIJ));
    if (mode != 2)
      chk("run_length", 64'(done_idx - first_idx + 1), 64'(2506 + ((mode == 1) ? 5 : 0)));
  endtask

  initial begin
    int exec_edges, exec_t;
    bit prev_exec, hit;
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", {30'd0, inst}, {30'd0, IDLE_W});
    chk("rst_sfp_clr", {63'd0, sfp_clr}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    run_schedule(0, 1'b1);
    run_schedule(1, 1'b0);
    run_schedule(2, 1'b1);
    chk("done_count", 64'(done_seen), 64'd3);

    // Abort with reset in the middle of EXEC for kij=2.
    start = 1'b1;
    ofifo_valid = 1'b1;
    exec_edges = 0;
    exec_t = 0;
    prev_exec = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inst[1] && !prev_exec) exec_edges++;
      if (exec_edges == 3 && inst[1]) begin
        exec_t++;
        if (exec_t == 10) hit = 1'b1;
      end
      prev_exec = inst[1];
    end
    chk("abort_reached_exec", {63'd0, hit}, 64'd1);
    chk("abort_in_exec", {62'd0, inst[3], inst[1]}, 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("abort_inst_async", {30'd0, inst}, {30'd0, IDLE_W});
    chk("abort_busy_async", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    vmode = 0;
    for (int i = 0; i < 20; i++) expect_cycle("post_abort", IDLE_W, 0, 0, 0, 0);
    chk("done_count_after_abort", 64'(done_seen), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
